// File: rtl/lock_ctrl_fsm.sv
// Password-lock controller: keypad entry, password storage and the lock state machine.
// Every output comes straight from a register or decodes the registered state.
module lock_ctrl_fsm #(
    parameter logic [15:0] DEFAULT_PW = 16'h1234,
    parameter int          MAX_ERR    = 3,
    parameter int          T_INPUT    = 1000000,
    parameter int          T_UNLOCK   = 2000000,
    parameter int          T_ERR      = 300000,
    parameter int          T_ALARM    = 2000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TICK,
    input  logic        KEY_VALID,
    input  logic [3:0]  KEY_DIGIT,
    input  logic        KEY_OK,
    input  logic        KEY_CLR,
    input  logic        ADMIN_REQ,
    output logic [2:0]  Current_State,
    output logic [15:0] Code,
    output logic [3:0]  Error_Times,
    output logic [20:0] COUNT_CLK,
    output logic        LOCK_OPEN,
    output logic        ALARM_ON
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'b000,
        S_INPUT  = 3'b001,
        S_UNLOCK = 3'b010,
        S_ERROR  = 3'b011,
        S_ALARM  = 3'b100,
        S_ADMIN  = 3'b101
    } state_t;

    localparam logic [20:0] LD_INPUT  = 21'(T_INPUT);
    localparam logic [20:0] LD_UNLOCK = 21'(T_UNLOCK);
    localparam logic [20:0] LD_ERR    = 21'(T_ERR);
    localparam logic [20:0] LD_ALARM  = 21'(T_ALARM);
    localparam logic [3:0]  MAX_ERR_V = 4'(MAX_ERR);

    state_t      state, state_n;
    logic [15:0] code, code_n;
    logic [2:0]  cnt, cnt_n;
    logic [3:0]  err, err_n;
    logic [20:0] count, count_n;
    logic [15:0] pw, pw_n;

    logic        digit_ok;
    logic        timeout;
    logic [3:0]  err_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_WAIT;
            code  <= 16'h0;
            cnt   <= 3'd0;
            err   <= 4'd0;
            count <= 21'd0;
            pw    <= DEFAULT_PW;
        end else begin
            state <= state_n;
            code  <= code_n;
            cnt   <= cnt_n;
            err   <= err_n;
            count <= count_n;
            pw    <= pw_n;
        end
    end

    // A key that is ignored in the current state does not mask lower-priority keys.
    always_comb begin
        state_n  = state;
        code_n   = code;
        cnt_n    = cnt;
        err_n    = err;
        pw_n     = pw;
        count_n  = (TICK && count != 21'd0) ? count - 21'd1 : count;
        digit_ok = KEY_VALID && (KEY_DIGIT <= 4'd9) && (cnt != 3'd4);
        timeout  = (count == 21'd0);
        err_inc  = (err == 4'hF) ? 4'hF : err + 4'd1;

        case (state)
            S_WAIT: begin
                code_n  = 16'h0;
                cnt_n   = 3'd0;
                count_n = 21'd0;
                if (KEY_VALID && KEY_DIGIT <= 4'd9) begin
                    code_n  = {12'h0, KEY_DIGIT};
                    cnt_n   = 3'd1;
                    count_n = LD_INPUT;
                    state_n = S_INPUT;
                end
            end
            S_INPUT: begin
                if (timeout) begin
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                end else if (KEY_CLR) begin
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                    count_n = LD_INPUT;
                end else if (KEY_OK) begin
                    if (cnt == 3'd4 && code == pw) begin
                        state_n = S_UNLOCK;
                        err_n   = 4'd0;
                        count_n = LD_UNLOCK;
                    end else begin
                        err_n = err_inc;
                        if (err_inc >= MAX_ERR_V) begin
                            state_n = S_ALARM;
                            count_n = LD_ALARM;
                        end else begin
                            state_n = S_ERROR;
                            count_n = LD_ERR;
                        end
                    end
                end else if (digit_ok) begin
                    code_n  = {code[11:0], KEY_DIGIT};
                    cnt_n   = cnt + 3'd1;
                    count_n = LD_INPUT;
                end
            end
            S_UNLOCK: begin
                if (timeout) begin
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                end else if (ADMIN_REQ) begin
                    state_n = S_ADMIN;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                    count_n = LD_INPUT;
                end
            end
            S_ERROR: begin
                if (timeout) begin
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                end
            end
            S_ALARM: begin
                if (timeout) begin
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                    err_n   = 4'd0;
                end
            end
            S_ADMIN: begin
                if (timeout) begin
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                end else if (KEY_CLR) begin
                    code_n = 16'h0;
                    cnt_n  = 3'd0;
                end else if (KEY_OK && cnt == 3'd4) begin
                    pw_n    = code;
                    state_n = S_WAIT;
                    code_n  = 16'h0;
                    cnt_n   = 3'd0;
                    count_n = 21'd0;
                end else if (digit_ok) begin
                    code_n  = {code[11:0], KEY_DIGIT};
                    cnt_n   = cnt + 3'd1;
                    count_n = LD_INPUT;
                end
            end
            default: begin
                state_n = S_WAIT;
                code_n  = 16'h0;
                cnt_n   = 3'd0;
                count_n = 21'd0;
            end
        endcase
    end

    assign Current_State = state;
    assign Code          = code;
    assign Error_Times   = err;
    assign COUNT_CLK     = count;
    assign LOCK_OPEN     = (state == S_UNLOCK) || (state == S_ADMIN);
    assign ALARM_ON      = (state == S_ALARM);

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Bench for lock_ctrl_fsm: vector table, directed multi-cycle sequences and
// random traffic checked against a digit-queue reference model.
module tb_lock_ctrl_fsm;

    localparam int T_IN = 10;
    localparam int T_UN = 20;
    localparam int T_ER = 5;
    localparam int T_AL = 20;

    localparam int M_WAIT = 0, M_INPUT = 1, M_UNLOCK = 2, M_ERROR = 3, M_ALARM = 4, M_ADMIN = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TICK = 1'b0;
    logic        KEY_VALID = 1'b0;
    logic [3:0]  KEY_DIGIT = 4'h0;
    logic        KEY_OK = 1'b0;
    logic        KEY_CLR = 1'b0;
    logic        ADMIN_REQ = 1'b0;
    logic [2:0]  Current_State;
    logic [15:0] Code;
    logic [3:0]  Error_Times;
    logic [20:0] COUNT_CLK;
    logic        LOCK_OPEN;
    logic        ALARM_ON;

    int errors = 0;
    int checks = 0;

    lock_ctrl_fsm #(
        .DEFAULT_PW(16'h1234), .MAX_ERR(3),
        .T_INPUT(T_IN), .T_UNLOCK(T_UN), .T_ERR(T_ER), .T_ALARM(T_AL)
    ) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK),
        .KEY_VALID(KEY_VALID), .KEY_DIGIT(KEY_DIGIT),
        .KEY_OK(KEY_OK), .KEY_CLR(KEY_CLR), .ADMIN_REQ(ADMIN_REQ),
        .Current_State(Current_State), .Code(Code), .Error_Times(Error_Times),
        .COUNT_CLK(COUNT_CLK), .LOCK_OPEN(LOCK_OPEN), .ALARM_ON(ALARM_ON)
    );

    initial forever #5 CLK = ~CLK;

    // Reference model: entered digits as a queue, password as a digit array.
    int m_st;
    int m_dq[$];
    int m_err;
    int m_tmr;
    int m_pw[4];

    function automatic int code_val();
        int v = 0;
        foreach (m_dq[i]) v = v * 16 + m_dq[i];
        return v;
    endfunction

    function automatic bit pw_match();
        if (m_dq.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_dq[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_st = M_WAIT;
        m_dq.delete();
        m_err = 0;
        m_tmr = 0;
        m_pw = '{1, 2, 3, 4};
    endtask

    task automatic model_step(input bit vld, input int dig, input bit ok, input bit clr,
                              input bit adm, input bit tk);
        bit dig_ok = vld && dig <= 9 && m_dq.size() < 4;
        int nt = (tk && m_tmr > 0) ? m_tmr - 1 : m_tmr;
        if (m_st == M_WAIT) begin
            m_dq.delete();
            nt = 0;
            if (vld && dig <= 9) begin
                m_dq.push_back(dig);
                nt = T_IN;
                m_st = M_INPUT;
            end
        end else if (m_tmr == 0) begin
            if (m_st == M_ALARM) m_err = 0;
            m_st = M_WAIT;
            m_dq.delete();
            nt = 0;
        end else if (m_st == M_INPUT) begin
            if (clr) begin
                m_dq.delete();
                nt = T_IN;
            end else if (ok) begin
                if (pw_match()) begin
                    m_err = 0;
                    m_st = M_UNLOCK;
                    nt = T_UN;
                end else begin
                    m_err = (m_err + 1 > 15) ? 15 : m_err + 1;
                    m_st = (m_err >= 3) ? M_ALARM : M_ERROR;
                    nt = (m_err >= 3) ? T_AL : T_ER;
                end
            end else if (dig_ok) begin
                m_dq.push_back(dig);
                nt = T_IN;
            end
        end else if (m_st == M_UNLOCK) begin
            if (adm) begin
                m_st = M_ADMIN;
                m_dq.delete();
                nt = T_IN;
            end
        end else if (m_st == M_ADMIN) begin
            if (clr) begin
                m_dq.delete();
            end else if (ok && m_dq.size() == 4) begin
                for (int i = 0; i < 4; i++) m_pw[i] = m_dq[i];
                m_st = M_WAIT;
                m_dq.delete();
                nt = 0;
            end else if (dig_ok) begin
                m_dq.push_back(dig);
                nt = T_IN;
            end
        end
        m_tmr = nt;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("state", int'(Current_State), m_st);
        check("code", int'(Code), code_val());
        check("err", int'(Error_Times), m_err);
        check("count", int'(COUNT_CLK), m_tmr);
        check("lock_open", int'(LOCK_OPEN), int'(m_st == M_UNLOCK || m_st == M_ADMIN));
        check("alarm_on", int'(ALARM_ON), int'(m_st == M_ALARM));
    endtask

    // Drive one cycle of inputs, step the model on the same edge, compare 1ns later.
    task automatic apply(input bit vld, input logic [3:0] dig, input bit ok, input bit clr,
                         input bit adm, input bit tk);
        KEY_VALID = vld; KEY_DIGIT = dig; KEY_OK = ok; KEY_CLR = clr;
        ADMIN_REQ = adm; TICK = tk;
        @(posedge CLK);
        #1;
        model_step(vld, int'(dig), ok, clr, adm, tk);
        KEY_VALID = 1'b0; KEY_OK = 1'b0; KEY_CLR = 1'b0; ADMIN_REQ = 1'b0;
        compare_model();
    endtask

    task automatic digit(input logic [3:0] d);
        apply(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press_ok();
        apply(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic enter4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) digit(v[i*4 +: 4]);
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_state"}, int'(Current_State), 0);
        check({tag, "_code"}, int'(Code), 0);
        check({tag, "_err"}, int'(Error_Times), 0);
        check({tag, "_count"}, int'(COUNT_CLK), 0);
        check({tag, "_lock"}, int'(LOCK_OPEN), 0);
        check({tag, "_alarm"}, int'(ALARM_ON), 0);
    endtask

    // Asynchronous reset pulse mid-cycle, outputs checked before the next edge.
    task automatic do_reset();
        RST = 1'b1;
        #2;
        expect_reset_values("async_rst");
        model_reset();
        RST = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic [3:0]  dig;
        logic        ok;
        logic        clr;
        logic        adm;
        logic [2:0]  st;
        logic [15:0] code;
        logic [3:0]  err;
        logic [20:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 4'd0, 21'd10};
        tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0012, 4'd0, 21'd10};
        tbl[2]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0012, 4'd0, 21'd9};
        tbl[3]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0123, 4'd0, 21'd10};
        tbl[4]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd1, 16'h1234, 4'd0, 21'd10};
        tbl[5]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 3'd1, 16'h1234, 4'd0, 21'd9};
        tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 4'd0, 21'd10};
        tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 4'd0, 21'd10};
        tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0012, 4'd0, 21'd10};
        tbl[9]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0123, 4'd0, 21'd10};
        tbl[10] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd1, 16'h1234, 4'd0, 21'd10};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h1234, 4'd0, 21'd20};

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        expect_reset_values("reset");
        RST = 1'b0;

        // Vector table: entry, invalid digit, 5th digit, OK+CLR, correct unlock.
        foreach (tbl[i]) begin
            apply(tbl[i].vld, tbl[i].dig, tbl[i].ok, tbl[i].clr, tbl[i].adm, 1'b1);
            check($sformatf("tbl%0d_state", i), int'(Current_State), int'(tbl[i].st));
            check($sformatf("tbl%0d_code", i), int'(Code), int'(tbl[i].code));
            check($sformatf("tbl%0d_err", i), int'(Error_Times), int'(tbl[i].err));
            check($sformatf("tbl%0d_count", i), int'(COUNT_CLK), int'(tbl[i].cnt));
        end
        check("unlock_lock_open", int'(LOCK_OPEN), 1);

        // Unlock hold: still open after 20 cycles, WAIT on the 21st.
        idle(20);
        check("unlock_hold_state", int'(Current_State), 2);
        idle(1);
        check("unlock_expire_state", int'(Current_State), 0);

        // Three wrong attempts.
        for (int k = 1; k <= 3; k++) begin
            enter4(16'h1235);
            press_ok();
            check($sformatf("wrong%0d_state", k), int'(Current_State), (k < 3) ? 3 : 4);
            check($sformatf("wrong%0d_err", k), int'(Error_Times), k);
            if (k < 3) begin
                idle(6);
                check($sformatf("wrong%0d_back_wait", k), int'(Current_State), 0);
            end
        end
        check("alarm_on", int'(ALARM_ON), 1);
        idle(20);
        check("alarm_hold_state", int'(Current_State), 4);
        idle(1);
        check("alarm_expire_state", int'(Current_State), 0);
        check("alarm_expire_err", int'(Error_Times), 0);

        // Password change to 9876.
        enter4(16'h1234);
        press_ok();
        apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("admin_state", int'(Current_State), 5);
        enter4(16'h9876);
        check("admin_entry_state", int'(Current_State), 5);
        check("admin_entry_code", int'(Code), 16'h9876);
        press_ok();
        check("admin_commit_state", int'(Current_State), 0);
        enter4(16'h9876);
        press_ok();
        check("newpw_unlock_state", int'(Current_State), 2);
        idle(21);
        enter4(16'h1234);
        press_ok();
        check("oldpw_rejected_state", int'(Current_State), 3);
        idle(6);

        // Inactivity timeout after a single digit; Error_Times (1) kept.
        digit(4'h7);
        check("timeout_entry_state", int'(Current_State), 1);
        check("timeout_entry_code", int'(Code), 16'h0007);
        idle(10);
        check("timeout_hold_state", int'(Current_State), 1);
        idle(1);
        check("timeout_state", int'(Current_State), 0);
        check("timeout_code", int'(Code), 0);
        check("timeout_err", int'(Error_Times), 1);

        // Reset during ADMIN drops the pending change and restores 1234.
        enter4(16'h9876);
        press_ok();
        apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        digit(4'h1);
        check("pre_rst_admin_state", int'(Current_State), 5);
        do_reset();
        enter4(16'h1234);
        press_ok();
        check("post_rst_default_pw", int'(Current_State), 2);
        idle(21);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < 4; i++) digit(4'(m_pw[i]));
                press_ok();
            end else begin
                int r = $urandom_range(0, 9);
                bit tk = ($urandom_range(0, 3) != 0);
                logic [3:0] d = 4'($urandom_range(0, 11));
                apply(r <= 4, d, r == 5, r == 6, r == 7, tk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
